// File: rtl/tx_frame_encoder.sv
// rtl/tx_frame_encoder.sv - 802.11a TX framer (SERVICE/PSDU/TAIL/PAD), scrambler and K=7 rate-1/2 encoder
// Define TX_SCRAMBLER_EN to include the x^7+x^4+1 scrambler; otherwise source bits feed the encoder directly.
module tx_frame_encoder #(
    parameter logic [6:0] SEED    = 7'b1111111,
    parameter int          NDATA_W = 12
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NDATA_W-1:0] n_data,
    input  logic [5:0]         n_pad,
    input  logic               data_in,
    input  logic               data_valid,
    output logic               ready,
    output logic [1:0]         data_out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SERVICE = 3'd1,
        ST_DATA    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_PAD     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NDATA_W-1:0] cnt_q, cnt_d;
    logic [NDATA_W-1:0] n_data_q, n_data_d;
    logic [5:0]         pad_q, pad_d;
    logic [5:0]         hist_q, hist_d;
    logic [1:0]         data_out_q, data_out_d;
    logic               out_valid_q, done_q;

    logic proc, src, force_zero, last, sb, enc_a, enc_b;

`ifdef TX_SCRAMBLER_EN
    logic [6:0] scr_q, scr_d;
    logic       fb;
`else
    logic unused_seed;
    assign unused_seed = ^SEED;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_data_d   = n_data_q;
        pad_d      = pad_q;
        proc       = 1'b0;
        src        = 1'b0;
        force_zero = 1'b0;
        last       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_data_d = n_data;
                    pad_d    = n_pad;
                    cnt_d    = NDATA_W'(16);
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                proc  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == NDATA_W'(1)) begin
                    if (n_data_q == '0) begin
                        state_d = ST_TAIL;
                        cnt_d   = NDATA_W'(6);
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = n_data_q;
                    end
                end
            end
            ST_DATA: begin
                if (data_valid) begin
                    proc  = 1'b1;
                    src   = data_in;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == NDATA_W'(1)) begin
                        state_d = ST_TAIL;
                        cnt_d   = NDATA_W'(6);
                    end
                end
            end
            ST_TAIL: begin
                proc       = 1'b1;
                force_zero = 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == NDATA_W'(1)) begin
                    if (pad_q == 6'd0) begin
                        state_d = ST_IDLE;
                        last    = 1'b1;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                proc  = 1'b1;
                pad_d = pad_q - 1'b1;
                if (pad_q == 6'd1) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tail bits are forced to zero after scrambling so the encoder flushes to state 0.
    always_comb begin
`ifdef TX_SCRAMBLER_EN
        fb    = scr_q[6] ^ scr_q[3];
        scr_d = scr_q;
        if (state_q == ST_IDLE && start) begin
            scr_d = SEED;
        end else if (proc) begin
            scr_d = {scr_q[5:0], fb};
        end
        sb = force_zero ? 1'b0 : (src ^ fb);
`else
        sb = force_zero ? 1'b0 : src;
`endif
        enc_a = sb ^ hist_q[1] ^ hist_q[2] ^ hist_q[4] ^ hist_q[5];
        enc_b = sb ^ hist_q[0] ^ hist_q[1] ^ hist_q[2] ^ hist_q[5];
        hist_d     = hist_q;
        data_out_d = data_out_q;
        if (state_q == ST_IDLE && start) begin
            hist_d = 6'd0;
        end else if (proc) begin
            hist_d     = {hist_q[4:0], sb};
            data_out_d = {enc_b, enc_a};
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_data_q    <= '0;
            pad_q       <= 6'd0;
            hist_q      <= 6'd0;
            data_out_q  <= 2'b00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_data_q    <= n_data_d;
            pad_q       <= pad_d;
            hist_q      <= hist_d;
            data_out_q  <= data_out_d;
            out_valid_q <= proc;
            done_q      <= last;
        end
    end

`ifdef TX_SCRAMBLER_EN
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            scr_q <= SEED;
        end else begin
            scr_q <= scr_d;
        end
    end
`endif

    assign ready     = (state_q == ST_DATA);
    assign busy      = (state_q != ST_IDLE);
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tx_frame_encoder.sv
// tb/tb_tx_frame_encoder.sv - randomized self-checking bench for tx_frame_encoder against a frame-level reference model
module tb_tx_frame_encoder;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] n_data = '0;
    logic [5:0]  n_pad = '0;
    logic        data_in = 1'b0;
    logic        data_valid = 1'b0;
    logic        ready;
    logic [1:0]  data_out;
    logic        out_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    logic [1:0] ref_q[$];
    bit dbits[0:4095];

    tx_frame_encoder #(.SEED(7'h7F), .NDATA_W(12)) dut (
        .Clk(Clk), .reset(reset), .start(start), .n_data(n_data), .n_pad(n_pad),
        .data_in(data_in), .data_valid(data_valid), .ready(ready), .data_out(data_out),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (out_valid) got_q.push_back(data_out);
        if (done) done_cnt++;
    end

    task automatic fill_bits();
        for (int i = 0; i < 4096; i++) dbits[i] = 1'($urandom);
    endtask

    // Frame = 16 zeros, PSDU, 6 zeros, pad zeros; tail is zeroed after scrambling; code by tap sums.
    function automatic void build_expected(input int nd, input int np);
        int n;
        bit b, a, bb;
        bit x[0:4300];
`ifdef TX_SCRAMBLER_EN
        logic [6:0] s;
        bit f;
        s = 7'h7F;
`endif
        n = 22 + nd + np;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = (i >= 16 && i < 16 + nd) ? dbits[i-16] : 1'b0;
`ifdef TX_SCRAMBLER_EN
            f = s[6] ^ s[3];
            b = b ^ f;
            s = {s[5:0], f};
`endif
            if (i >= 16 + nd && i < 22 + nd) b = 1'b0;
            x[i] = b;
        end
        for (int i = 0; i < n; i++) begin
            a  = x[i] ^ (i >= 2 ? x[i-2] : 1'b0) ^ (i >= 3 ? x[i-3] : 1'b0)
                      ^ (i >= 5 ? x[i-5] : 1'b0) ^ (i >= 6 ? x[i-6] : 1'b0);
            bb = x[i] ^ (i >= 1 ? x[i-1] : 1'b0) ^ (i >= 2 ? x[i-2] : 1'b0)
                      ^ (i >= 3 ? x[i-3] : 1'b0) ^ (i >= 6 ? x[i-6] : 1'b0);
            exp_q.push_back({bb, a});
        end
    endfunction

    task automatic drive_frame(input int nd, input int np, input int stall,
                               input bit issue, input bit hold, input int pulse_at);
        int idx, busy_cyc, rdy_cyc, stl, d0, first_bad;
        bit seen_done, dv;
        idx = 0; busy_cyc = 0; rdy_cyc = 0; stl = 0; seen_done = 1'b0;
        build_expected(nd, np);
        got_q.delete();
        d0 = done_cnt;
        if (issue) begin
            @(negedge Clk);
            start = 1'b1; n_data = 12'(nd); n_pad = 6'(np);
        end
        for (int c = 0; c < 6000 && !seen_done; c++) begin
            @(negedge Clk);
            if (c == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL busy_rise nd=%0d got=%b want=1", nd, busy);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                total++;
                if (busy !== 1'b0 || out_valid !== 1'b1) begin
                    bad++; $display("FAIL done_align nd=%0d busy=%b out_valid=%b want busy=0 out_valid=1", nd, busy, out_valid);
                end
            end else begin
                start = hold; n_data = 12'(nd); n_pad = 6'(np);
                if (c == pulse_at) begin
                    start = 1'b1; n_data = ~12'(nd); n_pad = ~6'(np);
                end
                if (busy) busy_cyc++;
                if (ready) begin
                    rdy_cyc++;
                    dv = (stall == 0) ? 1'b1 : (stall == 1) ? 1'(c % 2) : 1'($urandom);
                    data_valid = dv;
                    data_in = dv ? dbits[idx] : 1'($urandom);
                    if (dv) idx++; else stl++;
                end else begin
                    data_valid = 1'($urandom);
                    data_in = 1'($urandom);
                end
            end
        end
        total++;
        if (!seen_done) begin
            bad++; $display("FAIL frame_timeout nd=%0d np=%0d got=no_done want=done", nd, np);
        end
        #1;
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL frame_len nd=%0d np=%0d got=%0d want=%0d", nd, np, got_q.size(), exp_q.size());
        end
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (first_bad < 0 && got_q[i] !== exp_q[i]) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL frame_data nd=%0d np=%0d idx=%0d got=%b want=%b", nd, np, first_bad, got_q[first_bad], exp_q[first_bad]);
        end
        total++;
        if (done_cnt !== d0 + 1) begin
            bad++; $display("FAIL done_count nd=%0d got=%0d want=%0d", nd, done_cnt - d0, 1);
        end
        total++;
        if (busy_cyc !== 22 + nd + np + stl) begin
            bad++; $display("FAIL busy_cycles nd=%0d got=%0d want=%0d", nd, busy_cyc, 22 + nd + np + stl);
        end
        total++;
        if (rdy_cyc !== nd + stl) begin
            bad++; $display("FAIL ready_cycles nd=%0d got=%0d want=%0d", nd, rdy_cyc, nd + stl);
        end
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge Clk);
        total++;
        if ({ready, data_out, out_valid, busy, done} !== 6'b0) begin
            bad++; $display("FAIL reset_state got=%b want=000000", {ready, data_out, out_valid, busy, done});
        end
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_known_vector();
`ifdef TX_SCRAMBLER_EN
        logic [1:0] kv[5];
        kv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        drive_frame(0, 0, 0, 1'b1, 1'b0, -1);
        total++;
        if (got_q.size() !== 22) begin
            bad++; $display("FAIL kv_len got=%0d want=22", got_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== kv[i]) begin
                bad++; $display("FAIL kv_pair idx=%0d got=%b want=%b", i, (got_q.size() > i) ? got_q[i] : 2'bxx, kv[i]);
            end
        end
`else
        logic [1:0] kv[23];
        for (int i = 0; i < 16; i++) kv[i] = 2'b00;
        kv[16] = 2'b11; kv[17] = 2'b10; kv[18] = 2'b11; kv[19] = 2'b11;
        kv[20] = 2'b00; kv[21] = 2'b01; kv[22] = 2'b11;
        dbits[0] = 1'b1;
        drive_frame(1, 0, 0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 23; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== kv[i]) begin
                bad++; $display("FAIL kv_pair idx=%0d got=%b want=%b", i, (got_q.size() > i) ? got_q[i] : 2'bxx, kv[i]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        fill_bits();
        d0 = done_cnt;
        @(negedge Clk);
        start = 1'b1; n_data = 12'd20; n_pad = 6'd3;
        @(negedge Clk);
        start = 1'b0; data_valid = 1'b1;
        repeat (22) begin
            @(negedge Clk);
            data_in = 1'($urandom);
        end
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL mid_data_active ready=%b out_valid=%b want 1 1", ready, out_valid);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, ready, done, data_out} !== 6'b0) begin
            bad++; $display("FAIL async_reset got=%b want=000000", {out_valid, busy, ready, done, data_out});
        end
        @(negedge Clk);
        reset = 1'b1; data_valid = 1'b0;
        repeat (40) @(negedge Clk);
        total++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            bad++; $display("FAIL no_done_after_reset dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        drive_frame(20, 3, 0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_stall();
        fill_bits();
        drive_frame(8, 0, 0, 1'b1, 1'b0, -1);
        ref_q = got_q;
        drive_frame(8, 0, 1, 1'b1, 1'b0, -1);
        total++;
        if (got_q != ref_q) begin
            bad++; $display("FAIL stall_vs_unstalled got_len=%0d want_len=%0d", got_q.size(), ref_q.size());
        end
    endtask

    task automatic test_long_pad();
        fill_bits();
        drive_frame(100, 63, 2, 1'b1, 1'b0, 40);
        total++;
        if (got_q.size() !== 185) begin
            bad++; $display("FAIL long_pad_len got=%0d want=185", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] svc[$];
        fill_bits();
        drive_frame(5, 2, 2, 1'b1, 1'b1, -1);
        svc = got_q[0:15];
        drive_frame(5, 2, 0, 1'b0, 1'b0, -1);
        total++;
        if (got_q.size() < 16 || got_q[0:15] != svc) begin
            bad++; $display("FAIL b2b_service_repeat got_len=%0d want_len=16", got_q.size());
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            fill_bits();
            drive_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 12)), 2, 1'b1, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_reset_mid_frame();
        test_stall();
        test_long_pad();
        test_back_to_back();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
